// File: rtl/sm3_byte_packer.sv
// Packs a valid/ready byte stream MSB-first into 32-bit words for the SM3 core.
// Optional bit-length tracking is enabled by defining SM3_PACKER_LEN_EN.
module sm3_byte_packer #(
  parameter int LEN_W = 64
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             en_in,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid_in,
  input  logic             byte_last_in,
  output logic             byte_ready_out,
  output logic [31:0]      msg_out,
  output logic             msg_valid_out,
  input  logic             msg_ready_in,
  output logic             is_last_word_out,
  output logic [1:0]       last_word_byte_out,
  output logic [LEN_W-1:0] msg_len_out,
  output logic             len_ovf_out
);

  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] merged;
  logic        accept;
  logic        complete;

  // A byte may enter whenever the output slot is empty or being drained this cycle.
  assign byte_ready_out = en_in & (~msg_valid_out | msg_ready_in);
  assign accept         = byte_valid_in & byte_ready_out;
  assign complete       = (idx == 2'd3) | byte_last_in;

  always_comb begin
    merged = acc;
    case (idx)
      2'd0:    merged[31:24] = byte_in;
      2'd1:    merged[23:16] = byte_in;
      2'd2:    merged[15:8]  = byte_in;
      default: merged[7:0]   = byte_in;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      idx                <= 2'd0;
      acc                <= 32'd0;
      msg_out            <= 32'd0;
      msg_valid_out      <= 1'b0;
      is_last_word_out   <= 1'b0;
      last_word_byte_out <= 2'd0;
    end else if (!en_in) begin
      idx                <= 2'd0;
      acc                <= 32'd0;
      msg_out            <= 32'd0;
      msg_valid_out      <= 1'b0;
      is_last_word_out   <= 1'b0;
      last_word_byte_out <= 2'd0;
    end else begin
      if (msg_valid_out && msg_ready_in) begin
        msg_valid_out <= 1'b0;
      end
      // A completing byte overrides the drain above, so valid stays high on swap.
      if (accept) begin
        if (complete) begin
          msg_out            <= merged;
          msg_valid_out      <= 1'b1;
          is_last_word_out   <= byte_last_in;
          last_word_byte_out <= byte_last_in ? idx : 2'd0;
          idx                <= 2'd0;
          acc                <= 32'd0;
        end else begin
          acc <= merged;
          idx <= idx + 2'd1;
        end
      end
    end
  end

`ifdef SM3_PACKER_LEN_EN
  localparam logic [LEN_W:0] BYTE_BITS = (LEN_W+1)'(8);

  logic           new_msg;
  logic [LEN_W:0] len_sum;

  assign len_sum = {1'b0, msg_len_out} + BYTE_BITS;

  // new_msg marks that the next accepted byte restarts the count.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      new_msg     <= 1'b1;
      msg_len_out <= '0;
      len_ovf_out <= 1'b0;
    end else if (!en_in) begin
      new_msg     <= 1'b1;
      msg_len_out <= '0;
      len_ovf_out <= 1'b0;
    end else if (accept) begin
      new_msg <= byte_last_in;
      if (new_msg) begin
        msg_len_out <= BYTE_BITS[LEN_W-1:0];
      end else begin
        msg_len_out <= len_sum[LEN_W-1:0];
        if (len_sum[LEN_W]) begin
          len_ovf_out <= 1'b1;
        end
      end
    end
  end
`else
  assign msg_len_out = '0;
  assign len_ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_sm3_byte_packer.sv
// Scoreboard bench for sm3_byte_packer: directed byte vectors, expected words queued
// at issue time and checked by an independent monitor when the DUT hands a word over.
module tb_sm3_byte_packer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        en_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_last_in;
  logic        byte_ready_out;
  logic [31:0] msg_out;
  logic        msg_valid_out;
  logic        msg_ready_in;
  logic        is_last_word_out;
  logic [1:0]  last_word_byte_out;
  logic [63:0] msg_len_out;
  logic        len_ovf_out;

  logic        byte_ready8;
  logic [31:0] msg8;
  logic        msg_valid8;
  logic        is_last8;
  logic [1:0]  lwb8;
  logic [7:0]  len8;
  logic        ovf8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [1:0]  lwb;
    logic [63:0] len;
  } exp_t;

  exp_t expQ[$];

  always #5 clk_in = ~clk_in;

  sm3_byte_packer #(.LEN_W(64)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .en_in(en_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in),
    .byte_ready_out(byte_ready_out), .msg_out(msg_out), .msg_valid_out(msg_valid_out),
    .msg_ready_in(msg_ready_in), .is_last_word_out(is_last_word_out),
    .last_word_byte_out(last_word_byte_out), .msg_len_out(msg_len_out),
    .len_ovf_out(len_ovf_out)
  );

  sm3_byte_packer #(.LEN_W(8)) dut8 (
    .clk_in(clk_in), .reset_in(reset_in), .en_in(en_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in),
    .byte_ready_out(byte_ready8), .msg_out(msg8), .msg_valid_out(msg_valid8),
    .msg_ready_in(msg_ready_in), .is_last_word_out(is_last8),
    .last_word_byte_out(lwb8), .msg_len_out(len8),
    .len_ovf_out(ovf8)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input logic [31:0] w, input logic l, input logic [1:0] b, input logic [63:0] len);
    exp_t e;
    e.word = w;
    e.last = l;
    e.lwb  = b;
    e.len  = len;
    expQ.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic applyStimulus(input logic [7:0] b, input logic l);
    int waitCnt;
    waitCnt       = 0;
    byte_in       = b;
    byte_last_in  = l;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    while (!byte_ready_out && waitCnt < 200) begin
      @(negedge clk_in);
      waitCnt++;
    end
    if (!byte_ready_out) begin
      total++;
      bad++;
      $display("[TB] FAIL byte_accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk_in);
    #1;
    byte_valid_in = 1'b0;
    byte_last_in  = 1'b0;
  endtask

  // Monitor: a word is handed over at the next edge when valid and ready are both high.
  always @(negedge clk_in) begin
    if (!reset_in && msg_valid_out && msg_ready_in) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got %08h expected none", msg_out);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("word", 64'(msg_out), 64'(e.word));
        checkOutput("is_last_word", 64'(is_last_word_out), 64'(e.last));
        checkOutput("last_word_byte", 64'(last_word_byte_out), 64'(e.lwb));
`ifdef SM3_PACKER_LEN_EN
        if (e.last) checkOutput("msg_len_at_last", msg_len_out, e.len);
`else
        checkOutput("msg_len_tied", msg_len_out, 64'd0);
`endif
      end
    end
  end

  initial begin
    int waitCnt;
    reset_in      = 1'b1;
    en_in         = 1'b0;
    byte_in       = 8'd0;
    byte_valid_in = 1'b0;
    byte_last_in  = 1'b0;
    msg_ready_in  = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rst_valid", 64'(msg_valid_out), 64'd0);
    checkOutput("rst_msg", 64'(msg_out), 64'd0);
    checkOutput("rst_last", 64'(is_last_word_out), 64'd0);
    checkOutput("rst_lwb", 64'(last_word_byte_out), 64'd0);
    checkOutput("rst_len", msg_len_out, 64'd0);
    checkOutput("rst_ovf", 64'(len_ovf_out), 64'd0);
    checkOutput("rst_byte_ready", 64'(byte_ready_out), 64'd0);
    reset_in     = 1'b0;
    en_in        = 1'b1;
    msg_ready_in = 1'b1;
    @(posedge clk_in);
    #1;

    $display("[TB] 64-byte abcd message");
    for (int i = 0; i < 16; i++) expectWord(32'h61626364, i == 15, (i == 15) ? 2'b11 : 2'b00, 64'd512);
    for (int i = 0; i < 64; i++) applyStimulus(8'h61 + 8'(i % 4), i == 63);

    $display("[TB] abc message");
    expectWord(32'h61626300, 1'b1, 2'b10, 64'd24);
    applyStimulus(8'h61, 1'b0);
    applyStimulus(8'h62, 1'b0);
    applyStimulus(8'h63, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    $display("[TB] consumer stall");
    msg_ready_in = 1'b0;
    expectWord(32'h65666768, 1'b0, 2'b00, 64'd0);
    expectWord(32'h696a6b6c, 1'b1, 2'b11, 64'd64);
    applyStimulus(8'h65, 1'b0);
    applyStimulus(8'h66, 1'b0);
    applyStimulus(8'h67, 1'b0);
    applyStimulus(8'h68, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      checkOutput("stall_valid", 64'(msg_valid_out), 64'd1);
      checkOutput("stall_msg", 64'(msg_out), 64'h65666768);
      checkOutput("stall_byte_ready", 64'(byte_ready_out), 64'd0);
    end
    @(posedge clk_in);
    #1;
    msg_ready_in = 1'b1;
    applyStimulus(8'h69, 1'b0);
    applyStimulus(8'h6a, 1'b0);
    applyStimulus(8'h6b, 1'b0);
    applyStimulus(8'h6c, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    $display("[TB] enable drop mid-word");
    applyStimulus(8'h73, 1'b0);
    applyStimulus(8'h74, 1'b0);
    en_in = 1'b0;
    @(negedge clk_in);
    checkOutput("dis_byte_ready", 64'(byte_ready_out), 64'd0);
    @(posedge clk_in);
    #1;
    checkOutput("dis_len", msg_len_out, 64'd0);
    checkOutput("dis_valid", 64'(msg_valid_out), 64'd0);
    en_in = 1'b1;
    expectWord(32'h7778797a, 1'b1, 2'b11, 64'd32);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'h78, 1'b0);
    applyStimulus(8'h79, 1'b0);
    applyStimulus(8'h7a, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    $display("[TB] async reset mid-word");
    applyStimulus(8'h6d, 1'b0);
    applyStimulus(8'h6e, 1'b0);
    #2;
    reset_in = 1'b1;
    #1;
    checkOutput("areset_msg", 64'(msg_out), 64'd0);
    checkOutput("areset_valid", 64'(msg_valid_out), 64'd0);
    checkOutput("areset_len", msg_len_out, 64'd0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    expectWord(32'h70717200, 1'b1, 2'b10, 64'd24);
    applyStimulus(8'h70, 1'b0);
    applyStimulus(8'h71, 1'b0);
    applyStimulus(8'h72, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    $display("[TB] 33-byte length wrap");
    for (int w = 0; w < 8; w++) begin
      expectWord({8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)}, 1'b0, 2'b00, 64'd0);
    end
    expectWord(32'h21000000, 1'b1, 2'b00, 64'd264);
    for (int i = 1; i <= 33; i++) begin
      applyStimulus(8'(i), i == 33);
`ifdef SM3_PACKER_LEN_EN
      if (i == 31) begin
        checkOutput("len8_at_31", 64'(len8), 64'd248);
        checkOutput("ovf8_at_31", 64'(ovf8), 64'd0);
      end
      if (i == 32) begin
        checkOutput("len8_at_32", 64'(len8), 64'd0);
        checkOutput("ovf8_at_32", 64'(ovf8), 64'd1);
      end
      if (i == 33) begin
        checkOutput("len8_at_33", 64'(len8), 64'd8);
        checkOutput("ovf8_at_33", 64'(ovf8), 64'd1);
        checkOutput("len64_at_33", msg_len_out, 64'd264);
        checkOutput("ovf64_at_33", 64'(len_ovf_out), 64'd0);
      end
`else
      if (i == 32) begin
        checkOutput("len8_tied", 64'(len8), 64'd0);
        checkOutput("ovf8_tied", 64'(ovf8), 64'd0);
      end
`endif
    end

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 50) begin
      @(posedge clk_in);
      waitCnt++;
    end
    #1;
    checkOutput("words_outstanding", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
